// File: rtl/mem_wb_stage_pkg.sv
// Shared types and defaults for the MEM stage and MEM/WB pipeline register.
// Holds the handshake state encoding and the writeback bundle with its bubble value.
package mem_wb_stage_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_REG_W  = 5;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   typedef struct packed {
      logic                  reg_write;
      logic                  mem_to_reg;
      logic [DEF_DATA_W-1:0] rdata;
      logic [DEF_DATA_W-1:0] alu;
      logic [DEF_REG_W-1:0]  rd;
   } memwb_t;

   localparam memwb_t MEMWB_BUBBLE = '0;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory request/ack bus between the MEM stage (master) and the memory (slave).
// Address, write data and direction are held stable by the stage while mem_req is high.
interface mem_wb_stage_if
   import mem_wb_stage_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
);
   logic              mem_req;
   logic              mem_we;
   logic [DATA_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/mem_handshake_fsm.sv
// Memory handshake tracker: IDLE/WAIT state plus a wait counter bounding how long an access may stall.
// Stall and request gating are combinational; an ack on the timeout cycle wins over the abort.
module mem_handshake_fsm
   import mem_wb_stage_pkg::*;
#(
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic pending_i,
   input  logic mem_ack_i,
   output logic stall_o,
   output logic abort_o,
   output logic req_o
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout;

   assign timeout = (state_q == WAIT) && (cnt_q == CNT_W'(TIMEOUT));
   assign abort_o = timeout & ~mem_ack_i;
   assign req_o   = pending_i & ~timeout;
   assign stall_o = pending_i & ~(mem_ack_i | timeout);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (pending_i && !mem_ack_i) begin
               state_d = WAIT;
               cnt_d   = CNT_W'(1);
            end
         end
         WAIT: begin
            if (mem_ack_i || timeout) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage with MEM/WB register: issues the data access, stalls upstream until ack or timeout.
// Non-memory ops reach MEM/WB in 1 cycle; accesses insert one bubble per wait cycle.
module mem_wb_stage
   import mem_wb_stage_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int REG_W   = DEF_REG_W,
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              RegWrite_in,
   input  logic              MemtoReg_in,
   input  logic              MemRead_in,
   input  logic              MemWrite_in,
   input  logic [DATA_W-1:0] ALU_result_in,
   input  logic [DATA_W-1:0] reg_read_data_2_in,
   input  logic [REG_W-1:0]  EX_MEM_RegisterRd_in,
   mem_wb_stage_if.master    mem_bus,
   output logic              MEM_Stall,
   output logic              mem_err,
   output logic              RegWrite_out,
   output logic              MemtoReg_out,
   output logic [DATA_W-1:0] mem_read_data_out,
   output logic [DATA_W-1:0] ALU_result_out,
   output logic [REG_W-1:0]  MEM_WB_RegisterRd_out
);

   logic   pending;
   logic   stall;
   logic   abort;
   logic   req;
   memwb_t wb_q, wb_d;
   logic   err_q, err_d;

   assign pending = MemRead_in | MemWrite_in;

   mem_handshake_fsm #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_fsm (
      .clk       (clk),
      .reset     (reset),
      .pending_i (pending),
      .mem_ack_i (mem_bus.mem_ack),
      .stall_o   (stall),
      .abort_o   (abort),
      .req_o     (req)
   );

   assign mem_bus.mem_req   = req;
   assign mem_bus.mem_we    = MemWrite_in;
   assign mem_bus.mem_addr  = ALU_result_in;
   assign mem_bus.mem_wdata = reg_read_data_2_in;
   assign MEM_Stall         = stall;

   // Load data is kept only for a pure load; a simultaneous store wins and drops it.
   always_comb begin
      wb_d  = MEMWB_BUBBLE;
      err_d = err_q;
      if (abort) begin
         err_d = 1'b1;
      end else if (!stall) begin
         wb_d.reg_write  = RegWrite_in;
         wb_d.mem_to_reg = MemtoReg_in;
         wb_d.alu        = ALU_result_in;
         wb_d.rd         = EX_MEM_RegisterRd_in;
         wb_d.rdata      = (MemRead_in && !MemWrite_in && mem_bus.mem_ack)
                           ? mem_bus.mem_rdata : '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wb_q  <= MEMWB_BUBBLE;
         err_q <= 1'b0;
      end else begin
         wb_q  <= wb_d;
         err_q <= err_d;
      end
   end

   assign mem_err               = err_q;
   assign RegWrite_out          = wb_q.reg_write;
   assign MemtoReg_out          = wb_q.mem_to_reg;
   assign mem_read_data_out     = wb_q.rdata;
   assign ALU_result_out        = wb_q.alu;
   assign MEM_WB_RegisterRd_out = wb_q.rd;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed and random instructions, expected per-cycle
// stage behaviour is derived from the access outcome (wait count vs. timeout) and queued.
module tb_mem_wb_stage;

   localparam int TO = 15;

   typedef struct {
      bit          stall;
      bit          req;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          rw;
      bit          mtr;
      logic [31:0] rdo;
      logic [31:0] alu;
      logic [4:0]  rd;
      bit          err;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in;
   logic [31:0] ALU_result_in, reg_read_data_2_in;
   logic [4:0]  EX_MEM_RegisterRd_in;
   logic        MEM_Stall, mem_err, RegWrite_out, MemtoReg_out;
   logic [31:0] mem_read_data_out, ALU_result_out;
   logic [4:0]  MEM_WB_RegisterRd_out;

   int   checks = 0;
   int   errors = 0;
   bit   model_err = 1'b0;
   exp_t sb[$];

   mem_wb_stage_if #(.DATA_W(32)) mem_bus ();

   mem_wb_stage #(.DATA_W(32), .REG_W(5), .TIMEOUT(TO), .CNT_W(4)) dut (
      .clk                   (clk),
      .reset                 (reset),
      .RegWrite_in           (RegWrite_in),
      .MemtoReg_in           (MemtoReg_in),
      .MemRead_in            (MemRead_in),
      .MemWrite_in           (MemWrite_in),
      .ALU_result_in         (ALU_result_in),
      .reg_read_data_2_in    (reg_read_data_2_in),
      .EX_MEM_RegisterRd_in  (EX_MEM_RegisterRd_in),
      .mem_bus               (mem_bus),
      .MEM_Stall             (MEM_Stall),
      .mem_err               (mem_err),
      .RegWrite_out          (RegWrite_out),
      .MemtoReg_out          (MemtoReg_out),
      .mem_read_data_out     (mem_read_data_out),
      .ALU_result_out        (ALU_result_out),
      .MEM_WB_RegisterRd_out (MEM_WB_RegisterRd_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive_idle();
      RegWrite_in = 0; MemtoReg_in = 0; MemRead_in = 0; MemWrite_in = 0;
      ALU_result_in = '0; reg_read_data_2_in = '0; EX_MEM_RegisterRd_in = '0;
      mem_bus.mem_ack = 0; mem_bus.mem_rdata = '0;
   endtask

   // One instruction held in EX/MEM until it leaves. waitn = cycle index of the ack
   // (beyond TO means the memory never answers). The outcome is worked out up front.
   task automatic issue(input bit rw, input bit mtr, input bit mr, input bit mw,
                        input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                        input int waitn, input logic [31:0] rdata);
      bit   pend;
      bit   aborted;
      int   last;
      exp_t e;
      pend    = mr | mw;
      aborted = pend && (waitn > TO);
      last    = !pend ? 0 : (aborted ? TO : waitn);
      for (int k = 0; k <= last; k++) begin
         @(negedge clk);
         RegWrite_in = rw; MemtoReg_in = mtr; MemRead_in = mr; MemWrite_in = mw;
         ALU_result_in = alu; reg_read_data_2_in = wd; EX_MEM_RegisterRd_in = rd;
         mem_bus.mem_ack   = pend ? (k == waitn) : ($urandom_range(0, 3) == 0);
         mem_bus.mem_rdata = (pend && k == waitn) ? rdata : $urandom;
         e.stall = pend && (k < last);
         e.req   = pend && (k != TO);
         e.we    = mw;
         e.addr  = alu;
         e.wdata = wd;
         e.rw = 0; e.mtr = 0; e.rdo = '0; e.alu = '0; e.rd = '0;
         if (k == last && aborted) begin
            model_err = 1'b1;
         end else if (k == last) begin
            e.rw  = rw;
            e.mtr = mtr;
            e.alu = alu;
            e.rd  = rd;
            e.rdo = (mr && !mw) ? rdata : 32'h0;
         end
         e.err = model_err;
         sb.push_back(e);
      end
   endtask

   // Monitor: combinational signals just before the edge, MEM/WB just after it.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #4;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("MEM_Stall", 32'(MEM_Stall), 32'(e.stall));
            chk("mem_req", 32'(mem_bus.mem_req), 32'(e.req));
            if (e.req) begin
               chk("mem_we", 32'(mem_bus.mem_we), 32'(e.we));
               chk("mem_addr", mem_bus.mem_addr, e.addr);
               chk("mem_wdata", mem_bus.mem_wdata, e.wdata);
            end
            @(posedge clk);
            #1;
            chk("RegWrite_out", 32'(RegWrite_out), 32'(e.rw));
            chk("MemtoReg_out", 32'(MemtoReg_out), 32'(e.mtr));
            chk("mem_read_data_out", mem_read_data_out, e.rdo);
            chk("ALU_result_out", ALU_result_out, e.alu);
            chk("Rd_out", 32'(MEM_WB_RegisterRd_out), 32'(e.rd));
            chk("mem_err", 32'(mem_err), 32'(e.err));
         end
      end
   end

   initial begin
      int          kind;
      int          w;
      logic [31:0] a;
      reset = 1'b1;
      drive_idle();
      #3;
      chk("reset RegWrite_out", 32'(RegWrite_out), 0);
      chk("reset ALU_result_out", ALU_result_out, 0);
      chk("reset mem_err", 32'(mem_err), 0);
      chk("reset MEM_Stall", 32'(MEM_Stall), 0);
      @(negedge clk);
      reset = 1'b0;

      issue(1, 0, 0, 0, 32'h10, 32'h0, 5'd5, 0, 32'h0);
      issue(1, 1, 1, 0, 32'h40, 32'h0, 5'd7, 0, 32'hDEADBEEF);
      issue(0, 0, 0, 1, 32'h80, 32'hCAFEF00D, 5'd0, 3, 32'h0);
      issue(1, 1, 1, 0, 32'h100, 32'h0, 5'd1, 1, 32'h11111111);
      issue(1, 1, 1, 0, 32'h104, 32'h0, 5'd2, 1, 32'h22222222);
      issue(1, 1, 1, 0, 32'h108, 32'h0, 5'd3, 1, 32'h33333333);
      issue(1, 1, 1, 0, 32'h200, 32'h0, 5'd9, TO + 10, 32'h0);
      issue(1, 0, 0, 0, 32'h55, 32'h0, 5'd4, 0, 32'h0);

      for (int n = 0; n < 80; n++) begin
         kind = $urandom_range(0, 3);
         w    = $urandom_range(0, 3);
         if ($urandom_range(0, 15) == 0) w = ($urandom_range(0, 1) == 0) ? TO : TO + 3;
         a = $urandom;
         issue($urandom_range(0, 1), $urandom_range(0, 1), kind[0], kind[1], a,
               $urandom, 5'($urandom), w, $urandom);
      end

      // Reset in the middle of a wait, no clock edge needed for it to take effect.
      @(negedge clk);
      RegWrite_in = 1; MemRead_in = 1; ALU_result_in = 32'h300; EX_MEM_RegisterRd_in = 5'd6;
      mem_bus.mem_ack = 0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("pre-reset mem_err", 32'(mem_err), 1);
      reset = 1'b1;
      #1;
      chk("async RegWrite_out", 32'(RegWrite_out), 0);
      chk("async MemtoReg_out", 32'(MemtoReg_out), 0);
      chk("async mem_read_data_out", mem_read_data_out, 0);
      chk("async ALU_result_out", ALU_result_out, 0);
      chk("async Rd_out", 32'(MEM_WB_RegisterRd_out), 0);
      chk("async mem_err", 32'(mem_err), 0);
      drive_idle();
      #1;
      reset = 1'b0;
      model_err = 1'b0;

      // Ack on the exact timeout cycle only completes if the counter restarted from zero.
      issue(1, 1, 1, 0, 32'h400, 32'h0, 5'd12, TO, 32'hA5A5A5A5);
      issue(1, 0, 0, 0, 32'h77, 32'h0, 5'd13, 0, 32'h0);
      @(negedge clk);
      drive_idle();
      repeat (3) @(negedge clk);
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard drain: got %0d entries left expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
